// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: ALU control codes, major opcodes, funct3/funct7 values.
// Used by the decode stage and the ALU so both agree on one encoding.
package riscv_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SGE = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       reg_write;
    logic       is_branch;
    logic       br_invert;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extractor: picks the I/S/B/U/J format from the opcode and sign-extends.
// Purely combinational, no handshake.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0]  imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// Decode stage: one-deep registered payload between fetch and ALU, 1-cycle latency.
// Accepts when empty or draining (full throughput); flush drops the held slot and blocks loads.
module id_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int CTRL_BITS   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0]  pc,
  input  logic                   flush,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [DATA_WIDTH-1:0]  rs1_data,
  input  logic [DATA_WIDTH-1:0]  rs2_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [CTRL_BITS-1:0]   alu_ctrl,
  output logic [DATA_WIDTH-1:0]  imm,
  output logic [4:0]             rd_addr,
  output logic                   reg_write,
  output logic                   is_branch,
  output logic                   br_invert,
  output logic                   illegal,
  output logic [DATA_WIDTH-1:0]  out_pc
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [DATA_WIDTH-1:0] imm_raw;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  imm_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_imm_gen (
    .instr (instr),
    .imm   (imm_raw)
  );

  logic [3:0] d_alu;
  logic       d_legal, d_use_imm, d_branch, d_inv, d_wr;

  always_comb begin
    d_alu     = ALU_AND;
    d_legal   = 1'b0;
    d_use_imm = 1'b0;
    d_branch  = 1'b0;
    d_inv     = 1'b0;
    d_wr      = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_wr    = 1'b1;
        d_legal = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: d_alu = ALU_ADD;
          {F7_ALT,  F3_ADD}: d_alu = ALU_SUB;
          {F7_BASE, F3_AND}: d_alu = ALU_AND;
          {F7_BASE, F3_OR }: d_alu = ALU_OR;
          {F7_BASE, F3_SLT}: d_alu = ALU_SLT;
          default:           d_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        d_wr      = 1'b1;
        d_use_imm = 1'b1;
        d_legal   = 1'b1;
        case (funct3)
          F3_ADD:  d_alu = ALU_ADD;
          F3_AND:  d_alu = ALU_AND;
          F3_OR:   d_alu = ALU_OR;
          F3_SLT:  d_alu = ALU_SLT;
          default: d_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d_wr      = 1'b1;
        d_use_imm = 1'b1;
        d_alu     = ALU_ADD;
        d_legal   = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      end
      OPC_STORE: begin
        d_use_imm = 1'b1;
        d_alu     = ALU_ADD;
        d_legal   = funct3 inside {F3_B, F3_H, F3_W};
      end
      OPC_BRANCH: begin
        d_branch = 1'b1;
        d_legal  = 1'b1;
        case (funct3)
          F3_BEQ:  d_alu = ALU_SUB;
          F3_BNE: begin
            d_alu = ALU_SUB;
            d_inv = 1'b1;
          end
          F3_BLT:  d_alu = ALU_SLT;
          F3_BGE:  d_alu = ALU_SGE;
          default: d_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Illegal instructions leave a quiet payload: no write, no branch, zero operands.
  ctrl_t                 ctrl_d, ctrl_q;
  logic [DATA_WIDTH-1:0] a_d, b_d, imm_d;
  logic                  load;

  always_comb begin
    ctrl_d.alu_ctrl  = d_legal ? d_alu : ALU_AND;
    ctrl_d.reg_write = d_legal && d_wr && (rd != 5'd0);
    ctrl_d.is_branch = d_legal && d_branch;
    ctrl_d.br_invert = d_legal && d_inv;
    ctrl_d.illegal   = !d_legal;
    a_d              = d_legal ? rs1_data : '0;
    b_d              = !d_legal ? '0 : (d_use_imm ? imm_raw : rs2_data);
    imm_d            = d_legal ? imm_raw : '0;
  end

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      imm       <= '0;
      rd_addr   <= '0;
      out_pc    <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (load)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (load) begin
        ctrl_q  <= ctrl_d;
        alu_a   <= a_d;
        alu_b   <= b_d;
        imm     <= imm_d;
        rd_addr <= rd;
        out_pc  <= pc;
      end
    end
  end

  assign alu_ctrl  = CTRL_BITS'(ctrl_q.alu_ctrl);
  assign reg_write = ctrl_q.reg_write;
  assign is_branch = ctrl_q.is_branch;
  assign br_invert = ctrl_q.br_invert;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, operand width; INSTR_WIDTH, default 32, instruction width; CTRL_BITS, default 4, ALU control width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  instr/pc valid from fetch.
REQ-006 in_ready  out  1  stage can accept.
REQ-007 instr  in  INSTR_WIDTH  fetched instruction.
REQ-008 pc  in  DATA_WIDTH  instruction address.
REQ-009 flush  in  1  discard held instruction.
REQ-010 rs1_addr, rs2_addr  out  5 each  combinational register-file read addresses, instr[19:15] and instr[24:20].
REQ-011 rs1_data, rs2_data  in  DATA_WIDTH each  same-cycle register-file read data.
REQ-012 out_valid  out  1  execute-side payload valid.
REQ-013 out_ready  in  1  ALU stage accepts.
REQ-014 alu_a, alu_b  out  DATA_WIDTH each  registered ALU operands.
REQ-015 alu_ctrl  out  CTRL_BITS  registered ALU opcode.
REQ-016 imm  out  DATA_WIDTH  sign-extended immediate.
REQ-017 rd_addr  out  5; reg_write  out  1; is_branch  out  1; br_invert  out  1; illegal  out  1; out_pc  out  DATA_WIDTH.

Function
REQ-018 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SGE 0101, NOR 1100.
REQ-019 OP (0110011): funct3 000 -> ADD (funct7[5]=0) or SUB (=1); 111 AND; 110 OR; 010 SLT; alu_b=rs2_data; reg_write=1.
REQ-020 OP-IMM (0010011): funct3 000 ADD, 111 AND, 110 OR, 010 SLT; alu_b=I-imm; reg_write=1.
REQ-021 LOAD (0000011) and STORE (0100011): ADD, alu_b=I-imm / S-imm; reg_write=1 for LOAD only.
REQ-022 BRANCH (1100011): BEQ SUB br_invert=0; BNE SUB br_invert=1; BLT SLT; BGE SGE; alu_b=rs2_data; imm=B-imm; is_branch=1; reg_write=0.
REQ-023 Any other opcode/funct3/funct7 combination (XOR, shifts, unsigned compares, etc.): illegal=1, alu_ctrl=0000, reg_write=0, is_branch=0.
REQ-024 alu_a SHALL be rs1_data for all legal instructions; rd_addr=instr[11:7]; reg_write SHALL be forced 0 when rd_addr=0.
REQ-025 Immediates: I={20{i[31]},i[31:20]}; S={20{i[31]},i[31:25],i[11:7]}; B={19{i[31]},i[31],i[7],i[30:25],i[11:8],0}.
REQ-026 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-027 On rising edge with in_valid && in_ready: all output payload registers load decoded values, out_valid=1; latency exactly 1 cycle.
REQ-028 out_valid && out_ready without a new load SHALL clear out_valid; simultaneous accept-out and load-in SHALL leave out_valid=1 with new payload (full throughput, 1 instr/cycle).
REQ-029 While out_valid && !out_ready, all payload outputs SHALL hold stable.
REQ-030 flush SHALL clear out_valid next edge and block loading that cycle, overriding every other event.
REQ-031 Payload registers SHALL not change when no load occurs.

Reset
REQ-032 rst_n low SHALL immediately clear out_valid, alu_a, alu_b, alu_ctrl, imm, rd_addr, reg_write, is_branch, br_invert, illegal, out_pc to 0.
REQ-033 Reset mid-transfer SHALL drop the held instruction; first load allowed on the first edge after rst_n rises.

Structure
REQ-034 ALU codes, opcode and funct3 constants SHALL live in shared package riscv_pkg, also used by the ALU.
REQ-035 Immediate extraction SHALL be sub-module imm_gen (combinational, inputs instr, output imm by format).

Verification
REQ-036 instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle alu_ctrl=0010, alu_a=5, alu_b=7, rd_addr=3, reg_write=1.
REQ-037 instr 0x402081B3 (sub) -> alu_ctrl=0110; instr 0x00500093 (addi x1,x0,5) -> alu_b=5, alu_ctrl=0010.
REQ-038 instr 0x00208463 (beq x1,x2,8) -> alu_ctrl=0110, imm=8, is_branch=1, reg_write=0.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, payload stable; out_ready=1 -> back-to-back transfers, no loss or duplication.
REQ-040 flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, new instr not loaded; instr 0x0020C1B3 (xor) -> illegal=1, alu_ctrl=0000.
REQ-041 rst_n pulsed low asynchronously mid-cycle with out_valid=1 -> all outputs 0 immediately.
